// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run/done control path: state codes common to the
// control FSM and the work-length timer, plus the default counter width.
// Pure declarations, no logic, no latency, no flow control.
package run_ctrl_pkg;

  // State codes shared with the control FSM; 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } run_state_e;

  // Default width of the run length and elapsed-cycle counter (legal 2..16).
  localparam int RUN_CNT_W_DEF = 8;

endpackage : run_ctrl_pkg

// File: rtl/run_timer.sv
// Work-length timer feeding the control FSM's is_done: counts in_len cycles, then pulses out_done.
// Latency: start accepted at edge k -> out_done high from edge k+N (k for N=0) for one cycle.
// No backpressure: in_start is only sampled in IDLE; optional abort via RUN_TIMER_ABORT_EN.
module run_timer
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W = RUN_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_start,
  input  logic [CNT_W-1:0] in_len,
`ifdef RUN_TIMER_ABORT_EN
  input  logic             in_abort,
`endif
  output logic             out_busy,
  output logic             out_done,
  output logic [CNT_W-1:0] out_count
);

  run_state_e       state_q;
  logic [CNT_W-1:0] len_q;
  logic             abort_hit;
  logic             last_cycle;

  // Abort request, tied off when the feature is not built in.
`ifdef RUN_TIMER_ABORT_EN
  assign abort_hit = in_abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Terminal count: this edge moves the counter onto len_q.
  assign last_cycle = (out_count == (len_q - 1'b1));

  // Run/done state machine with registered outputs; the counter lives inline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      out_busy  <= 1'b0;
      out_done  <= 1'b0;
      out_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_done <= 1'b0;
          if (in_start) begin
            len_q     <= in_len;
            out_count <= '0;
            if (in_len == '0) begin
              // Zero-length run: straight to the done pulse, never busy.
              state_q  <= DONE;
              out_busy <= 1'b0;
              out_done <= 1'b1;
            end else begin
              state_q  <= COUNT;
              out_busy <= 1'b1;
            end
          end else begin
            state_q  <= IDLE;
            out_busy <= 1'b0;
          end
        end

        COUNT: begin
          // The cycle in progress counts as elapsed even when aborted.
          out_count <= out_count + 1'b1;
          if (abort_hit) begin
            // Abort wins over terminal count; no done pulse.
            state_q  <= IDLE;
            out_busy <= 1'b0;
            out_done <= 1'b0;
          end else if (last_cycle) begin
            state_q  <= DONE;
            out_busy <= 1'b0;
            out_done <= 1'b1;
          end else begin
            state_q  <= COUNT;
            out_busy <= 1'b1;
            out_done <= 1'b0;
          end
        end

        DONE: begin
          // One-cycle pulse, then back to IDLE whatever in_start is doing.
          state_q  <= IDLE;
          out_busy <= 1'b0;
          out_done <= 1'b0;
        end

        default: begin
          // Unused code: recover to IDLE with all outputs cleared.
          state_q   <= IDLE;
          out_busy  <= 1'b0;
          out_done  <= 1'b0;
          out_count <= '0;
        end
      endcase
    end
  end

endmodule : run_timer

// File: tb/tb_run_timer.sv
// Directed self-checking bench for run_timer, including a small control-FSM
// model driving in_start and consuming out_done. Abort scenarios are compiled
// only when RUN_TIMER_ABORT_EN is defined.
module tb_run_timer;
  import run_ctrl_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_drv;
  logic         start_w;
  logic [W-1:0] len_drv;
  logic         abort_drv;
  logic         busy;
  logic         done;
  logic [W-1:0] count;

  // Control FSM model: IDLE -> RUN on fsm_run (issuing one start), RUN -> DONE on is_done.
  run_state_e   fsm_state;
  logic         fsm_run;
  logic         fsm_start;
  logic         fsm_done;

  int errors = 0;
  int checks = 0;

  assign start_w = start_drv | fsm_start;

  run_timer #(.CNT_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_start  (start_w),
    .in_len    (len_drv),
`ifdef RUN_TIMER_ABORT_EN
    .in_abort  (abort_drv),
`endif
    .out_busy  (busy),
    .out_done  (done),
    .out_count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_state <= IDLE;
      fsm_start <= 1'b0;
      fsm_done  <= 1'b0;
    end else begin
      case (fsm_state)
        IDLE: begin
          fsm_done <= 1'b0;
          if (fsm_run) begin
            fsm_state <= COUNT;
            fsm_start <= 1'b1;
          end
        end
        COUNT: begin
          fsm_start <= 1'b0;
          if (done) begin
            fsm_state <= DONE;
            fsm_done  <= 1'b1;
          end
        end
        default: begin
          fsm_state <= IDLE;
          fsm_done  <= 1'b0;
          fsm_start <= 1'b0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_drv = 1'b0; len_drv = '0; abort_drv = 1'b0; fsm_run = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    #10 rst_n = 1'b1;
    tick();
    // Mid-run reset: len=10, hit reset at count=4.
    len_drv = 8'd10; start_drv = 1'b1; tick(); start_drv = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (count !== 8'd4 || busy !== 1'b1) begin errors++; $display("FAIL reset_pre got=%0d/%b exp=4/1", count, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL reset_async got=%b/%b/%0d exp=0/0/0", busy, done, count);
    end
    tick();
    #2 rst_n = 1'b1;
    begin
      int seen_done = 0;
      int seen_busy = 0;
      for (int i = 0; i < 14; i++) begin
        tick();
        if (done) seen_done++;
        if (busy) seen_busy++;
      end
      checks++; if (seen_done != 0 || seen_busy != 0) begin
        errors++; $display("FAIL reset_abort_run got done=%0d busy=%0d exp=0/0", seen_done, seen_busy);
      end
    end
  endtask

  task automatic test_basic();
    len_drv = 8'd5; start_drv = 1'b1; tick(); start_drv = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL basic_k got=%b/%b/%0d exp=1/0/0", busy, done, count);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++; if (busy !== 1'b1 || done !== 1'b0 || count !== W'(i)) begin
        errors++; $display("FAIL basic_cnt%0d got=%b/%b/%0d exp=1/0/%0d", i, busy, done, count, i);
      end
    end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1 || count !== 8'd5) begin
      errors++; $display("FAIL basic_done got=%b/%b/%0d exp=0/1/5", busy, done, count);
    end
    tick(); tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 8'd5) begin
      errors++; $display("FAIL basic_hold got=%b/%b/%0d exp=0/0/5", busy, done, count);
    end
  endtask

  task automatic test_boundaries();
    // Zero length.
    len_drv = 8'd0; start_drv = 1'b1; tick(); start_drv = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b1 || count !== 8'd0) begin
      errors++; $display("FAIL len0_done got=%b/%b/%0d exp=0/1/0", busy, done, count);
    end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL len0_after got=%b/%b exp=0/0", busy, done);
    end
    tick();
    // Length one.
    len_drv = 8'd1; start_drv = 1'b1; tick(); start_drv = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || count !== 8'd0) begin
      errors++; $display("FAIL len1_busy got=%b/%b/%0d exp=1/0/0", busy, done, count);
    end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1 || count !== 8'd1) begin
      errors++; $display("FAIL len1_done got=%b/%b/%0d exp=0/1/1", busy, done, count);
    end
    tick(); tick();
    // Maximum length, no wrap.
    len_drv = 8'd255; start_drv = 1'b1; tick(); start_drv = 1'b0;
    begin
      int busy_n = 0;
      int got_done = 0;
      for (int i = 0; i < 300 && got_done == 0; i++) begin
        if (busy) busy_n++;
        if (done) got_done = 1;
        else tick();
      end
      checks++; if (got_done != 1 || busy_n != 255 || count !== 8'd255) begin
        errors++; $display("FAIL len255 got done=%0d busy=%0d cnt=%0d exp=1/255/255", got_done, busy_n, count);
      end
    end
    tick(); tick();
    checks++; if (count !== 8'd255 || done !== 1'b0) begin
      errors++; $display("FAIL len255_hold got=%0d/%b exp=255/0", count, done);
    end
  endtask

  task automatic test_ignored();
    len_drv = 8'd6; start_drv = 1'b1; tick(); start_drv = 1'b0;
    begin
      int n = 0;
      int got_done = 0;
      for (int i = 0; i < 20 && got_done == 0; i++) begin
        tick(); n++;
        if (n == 2) begin len_drv = 8'd2; start_drv = 1'b1; end
        if (n == 4) start_drv = 1'b0;
        if (done) got_done = 1;
      end
      checks++; if (got_done != 1 || n != 6 || count !== 8'd6) begin
        errors++; $display("FAIL ignore_len got done=%0d cycles=%0d cnt=%0d exp=1/6/6", got_done, n, count);
      end
    end
    tick(); tick();
    // Start held high: runs separated by one IDLE cycle.
    len_drv = 8'd2; start_drv = 1'b1;
    begin
      logic [7:0] b;
      logic [7:0] d;
      b = '0; d = '0;
      for (int i = 0; i < 8; i++) begin
        tick();
        b[i] = busy;
        d[i] = done;
      end
      start_drv = 1'b0;
      checks++; if (b !== 8'b00110011) begin errors++; $display("FAIL b2b_busy got=%b exp=00110011", b); end
      checks++; if (d !== 8'b01000100) begin errors++; $display("FAIL b2b_done got=%b exp=01000100", d); end
    end
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

`ifdef RUN_TIMER_ABORT_EN
  task automatic test_abort();
    len_drv = 8'd8; start_drv = 1'b1; tick(); start_drv = 1'b0;
    tick(); tick(); tick();
    abort_drv = 1'b1; tick(); abort_drv = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 8'd4) begin
      errors++; $display("FAIL abort_mid got=%b/%b/%0d exp=0/0/4", busy, done, count);
    end
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (done || busy) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_quiet got=%0d exp=0", seen); end
    end
    // Abort on the terminal-count edge.
    len_drv = 8'd3; start_drv = 1'b1; tick(); start_drv = 1'b0;
    tick(); tick();
    abort_drv = 1'b1; tick(); abort_drv = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || count !== 8'd3) begin
      errors++; $display("FAIL abort_tc got=%b/%b/%0d exp=0/0/3", busy, done, count);
    end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_tc_after got=%b exp=0", done); end
  endtask
`endif

  task automatic test_fsm();
    int t_idx = -1;
    int f_idx = -1;
    int f_n = 0;
    len_drv = 8'd3;
    fsm_run = 1'b1; tick(); fsm_run = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done && t_idx < 0) t_idx = i;
      if (fsm_done) begin f_n++; if (f_idx < 0) f_idx = i; end
    end
    checks++; if (t_idx != 4) begin errors++; $display("FAIL fsm_timer_done got=%0d exp=4", t_idx); end
    checks++; if (f_idx != 5 || f_n != 1) begin
      errors++; $display("FAIL fsm_done got=%0d width=%0d exp=5/1", f_idx, f_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignored();
`ifdef RUN_TIMER_ABORT_EN
    test_abort();
`endif
    test_fsm();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_run_timer
